// File: rtl/seq_gen_pkg.sv
// Shared types and constants for the serial pattern generator:
// FSM state encoding and the PRBS7 (x^7 + x^6 + 1) seed/taps.
package seq_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_SEND = 2'b01,
    ST_GAP  = 2'b10,
    ST_DONE = 2'b11
  } state_t;

  localparam logic [6:0] PRBS7_SEED  = 7'h7F;
  localparam int         PRBS7_TAP_A = 6;  // x^7 term
  localparam int         PRBS7_TAP_B = 5;  // x^6 term

  // One Fibonacci step: shift left, feed back the XOR of the two taps.
  function automatic logic [6:0] prbs7_next(input logic [6:0] s);
    return {s[5:0], s[PRBS7_TAP_A] ^ s[PRBS7_TAP_B]};
  endfunction

endpackage

// File: rtl/seq_prbs7.sv
// PRBS7 LFSR used to fill inter-frame gaps with pseudo-random bits.
// bit_o is the MSB of the current state; adv_i steps the register.
module seq_prbs7
  import seq_gen_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic adv_i,
  output logic bit_o
);

  logic [6:0] lfsr_q;

  // Seed on reset, advance only when the owner consumes a bit.
  always_ff @(posedge clk) begin
    if (rst)        lfsr_q <= PRBS7_SEED;
    else if (adv_i) lfsr_q <= prbs7_next(lfsr_q);
  end

  assign bit_o = lfsr_q[6];

endmodule

// File: rtl/seq_pattern_generator.sv
// Serial pattern transmitter: sends a PAT_W-bit pattern MSB first for a
// programmed number of frames, with gap_len idle cycles between frames.
// Optional feature macro: SEQ_GEN_PRBS_GAP_EN -- gaps carry PRBS7 bits
// instead of IDLE_BIT.
module seq_pattern_generator
  import seq_gen_pkg::*;
#(
  parameter int               PAT_W       = 3,
  parameter logic [PAT_W-1:0] PATTERN_RST = 3'b101,
  parameter logic             IDLE_BIT    = 1'b0,
  parameter int               CNT_W       = 8,
  parameter int               GAP_W       = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_en,
  input  logic [PAT_W-1:0] load_pattern,
  input  logic             start,
  input  logic [CNT_W-1:0] frame_count,
  input  logic [GAP_W-1:0] gap_len,
  output logic             out_bit,
  output logic             frame_start,
  output logic             frame_last,
  output logic             busy,
  output logic             done
);

  localparam int               IDX_W    = (PAT_W > 2) ? $clog2(PAT_W) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PAT_W - 1);

  state_t           state_q;
  logic [PAT_W-1:0] pat_q, pat_d, shift_q;
  logic [IDX_W-1:0] idx_q;
  logic [CNT_W-1:0] frames_q;
  logic [GAP_W-1:0] gap_len_q, gap_cnt_q;
  logic             out_bit_q, frame_start_q, frame_last_q, busy_q, done_q;
  logic             more_frames;
  logic             gap_bit;

  // A load coincident with start must feed the run being started.
  assign pat_d       = load_en ? load_pattern : pat_q;
  assign more_frames = frames_q > CNT_W'(1);

`ifdef SEQ_GEN_PRBS_GAP_EN
  logic gap_adv;
  // Step the LFSR on every edge that lands in (or stays in) GAP.
  assign gap_adv = ((state_q == ST_SEND) && (idx_q == IDX_LAST) && more_frames &&
                    (gap_len_q != '0)) ||
                   ((state_q == ST_GAP) && (gap_cnt_q != '0));
  seq_prbs7 u_prbs7 (
    .clk   (clk),
    .rst   (rst),
    .adv_i (gap_adv),
    .bit_o (gap_bit)
  );
`else
  assign gap_bit = IDLE_BIT;
`endif

  // Main FSM; every output is registered with the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      pat_q         <= PATTERN_RST;
      shift_q       <= '0;
      idx_q         <= '0;
      frames_q      <= '0;
      gap_len_q     <= '0;
      gap_cnt_q     <= '0;
      out_bit_q     <= IDLE_BIT;
      frame_start_q <= 1'b0;
      frame_last_q  <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      frame_start_q <= 1'b0;
      frame_last_q  <= 1'b0;
      done_q        <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          pat_q     <= pat_d;
          out_bit_q <= IDLE_BIT;
          busy_q    <= 1'b0;
          if (start) begin
            frames_q  <= frame_count;
            gap_len_q <= gap_len;
            idx_q     <= '0;
            busy_q    <= 1'b1;
            if (frame_count != '0) begin
              state_q       <= ST_SEND;
              shift_q       <= pat_d;
              out_bit_q     <= pat_d[PAT_W-1];
              frame_start_q <= 1'b1;
            end else begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end
          end
        end
        ST_SEND: begin
          if (idx_q != IDX_LAST) begin
            idx_q        <= idx_q + 1'b1;
            shift_q      <= {shift_q[PAT_W-2:0], 1'b0};
            out_bit_q    <= shift_q[PAT_W-2];
            frame_last_q <= (idx_q + 1'b1) == IDX_LAST;
          end else begin
            frames_q <= frames_q - 1'b1;
            idx_q    <= '0;
            if (!more_frames) begin
              state_q   <= ST_DONE;
              out_bit_q <= IDLE_BIT;
              done_q    <= 1'b1;
            end else if (gap_len_q == '0) begin
              shift_q       <= pat_q;
              out_bit_q     <= pat_q[PAT_W-1];
              frame_start_q <= 1'b1;
            end else begin
              state_q   <= ST_GAP;
              gap_cnt_q <= gap_len_q - 1'b1;
              out_bit_q <= gap_bit;
            end
          end
        end
        ST_GAP: begin
          if (gap_cnt_q != '0) begin
            gap_cnt_q <= gap_cnt_q - 1'b1;
            out_bit_q <= gap_bit;
          end else begin
            state_q       <= ST_SEND;
            shift_q       <= pat_q;
            out_bit_q     <= pat_q[PAT_W-1];
            frame_start_q <= 1'b1;
          end
        end
        default: begin  // ST_DONE
          state_q   <= ST_IDLE;
          out_bit_q <= IDLE_BIT;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  assign out_bit     = out_bit_q;
  assign frame_start = frame_start_q;
  assign frame_last  = frame_last_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_seq_pattern_generator.sv
// Directed bench for seq_pattern_generator: each run's expected output
// stream is built as a queue and compared cycle by cycle after each edge.
module tb_seq_pattern_generator;

  logic       clk = 1'b0;
  logic       rst, load_en, start;
  logic [2:0] load_pattern;
  logic [7:0] frame_count;
  logic [3:0] gap_len;
  logic       out_bit, frame_start, frame_last, busy, done;

  always #5 clk = ~clk;

  seq_pattern_generator dut (
    .clk          (clk),
    .rst          (rst),
    .load_en      (load_en),
    .load_pattern (load_pattern),
    .start        (start),
    .frame_count  (frame_count),
    .gap_len      (gap_len),
    .out_bit      (out_bit),
    .frame_start  (frame_start),
    .frame_last   (frame_last),
    .busy         (busy),
    .done         (done)
  );

  typedef struct {
    logic  ob;
    logic  fs;
    logic  fl;
    logic  bz;
    logic  dn;
    string tag;
  } exp_t;

  exp_t       run_q[$];
  int         n_chk  = 0;
  int         n_fail = 0;
  int         fl_cnt = 0;
  logic [6:0] m_lfsr = 7'h7F;

  function automatic exp_t mk(logic ob, logic fs, logic fl, logic bz, logic dn, string tag);
    exp_t e;
    e.ob = ob; e.fs = fs; e.fl = fl; e.bz = bz; e.dn = dn; e.tag = tag;
    return e;
  endfunction

  // Expected gap fill bit: PRBS7 x^7+x^6+1 reference, or the idle level.
  function automatic logic next_gap_bit();
    logic b;
`ifdef SEQ_GEN_PRBS_GAP_EN
    b      = m_lfsr[6];
    m_lfsr = {m_lfsr[5:0], m_lfsr[6] ^ m_lfsr[5]};
`else
    b      = 1'b0;
`endif
    return b;
  endfunction

  // Expected per-cycle outputs for a run, starting on the cycle after start.
  task automatic build(input logic [2:0] pat, input int f, input int g, input string tag);
    run_q.delete();
    for (int fr = 0; fr < f; fr++) begin
      for (int b = 0; b < 3; b++)
        run_q.push_back(mk(pat[2-b], b == 0, b == 2, 1'b1, 1'b0,
                           $sformatf("%s_f%0d_b%0d", tag, fr, b)));
      if (fr < f - 1)
        for (int k = 0; k < g; k++)
          run_q.push_back(mk(next_gap_bit(), 1'b0, 1'b0, 1'b1, 1'b0,
                             $sformatf("%s_gap%0d_%0d", tag, fr, k)));
    end
    run_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, {tag, "_done"}));
  endtask

  task automatic chk1(input logic act, input logic exp, input string tag, input string fld);
    n_chk++;
    assert (act === exp) else begin
      n_fail++;
      $error("FAIL %s.%s: got %b expected %b", tag, fld, act, exp);
    end
  endtask

  task automatic chk_int(input int act, input int exp, input string tag);
    n_chk++;
    assert (act === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Advance one edge, then compare outputs against the expected entry.
  task automatic cyc(input exp_t e);
    @(posedge clk);
    #1;
    chk1(out_bit,     e.ob, e.tag, "out_bit");
    chk1(frame_start, e.fs, e.tag, "frame_start");
    chk1(frame_last,  e.fl, e.tag, "frame_last");
    chk1(busy,        e.bz, e.tag, "busy");
    chk1(done,        e.dn, e.tag, "done");
    if (frame_last === 1'b1) fl_cnt++;
    #1;
  endtask

  // Start a run; at cycle index 'poke' fire start+load while busy.
  task automatic run(input int f, input int g, input bit ld, input logic [2:0] lp,
                     input logic [2:0] pat, input int poke, input string tag);
    build(pat, f, g, tag);
    frame_count  = 8'(f);
    gap_len      = 4'(g);
    load_en      = ld;
    load_pattern = lp;
    start        = 1'b1;
    foreach (run_q[i]) begin
      cyc(run_q[i]);
      start   = 1'b0;
      load_en = 1'b0;
      if (i + 1 == poke) begin
        start        = 1'b1;
        load_en      = 1'b1;
        load_pattern = 3'b011;
        frame_count  = 8'd9;
        gap_len      = 4'd5;
      end
    end
    start   = 1'b0;
    load_en = 1'b0;
    cyc(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, {tag, "_idle"}));
  endtask

  initial begin
    int fl0;
    rst = 1'b1; load_en = 1'b0; start = 1'b0;
    load_pattern = 3'b000; frame_count = 8'd0; gap_len = 4'd0;

    // Reset state
    cyc(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "rst0"));
    cyc(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "rst1"));
    rst = 1'b0;
    cyc(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "idle0"));

    // 1: default pattern, single frame
    run(1, 0, 1'b0, 3'b000, 3'b101, -1, "t1");

    // 2: three frames, gap of two; count frame_last pulses
    fl0 = fl_cnt;
    run(3, 2, 1'b0, 3'b000, 3'b101, -1, "t2");
    chk_int(fl_cnt - fl0, 3, "t2_frame_last_count");

    // 3: load+start together, back-to-back frames, pokes while busy ignored
    run(2, 0, 1'b1, 3'b110, 3'b110, 2, "t3");
    run(1, 0, 1'b0, 3'b000, 3'b110, -1, "t3b");

    // 4: zero frames -> straight to DONE
    run(0, 3, 1'b0, 3'b000, 3'b110, -1, "t4");

    // 5: reset in the middle of frame 2 of 4
    build(3'b110, 4, 1, "t5");
    frame_count = 8'd4; gap_len = 4'd1; start = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc(run_q[i]);
      start = 1'b0;
    end
    rst = 1'b1;
    cyc(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "t5_rst"));
    rst    = 1'b0;
    m_lfsr = 7'h7F;
    cyc(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "t5_post"));
    run(1, 0, 1'b0, 3'b000, 3'b101, -1, "t5_pat");

`ifdef SEQ_GEN_PRBS_GAP_EN
    // 6: PRBS-filled gap of 7 between two intact frames
    run(2, 7, 1'b0, 3'b000, 3'b101, -1, "t6");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
